// File: rtl/led_tone_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_tone_arbiter
// Brief    : Fixed-priority owner of the colour LEDs and tone select, shared
//            between playback, player echo and win/lose animations.
// Revision : 1.0 - initial release
// ============================================================================
module led_tone_arbiter #(
    parameter int PLAY_TICKS  = 8,
    parameter int ECHO_TICKS  = 4,
    parameter int WIN_LOOPS   = 2,
    parameter int LOSE_BLINKS = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TICK,
    input  logic       PB_REQ,
    input  logic [1:0] PB_COLOR,
    input  logic       IN_VALID,
    input  logic [1:0] IN,
    input  logic       WIN,
    input  logic       LOSE,
    output logic [3:0] LED,
    output logic [1:0] TONE,
    output logic       TONE_EN,
    output logic       BUSY,
    output logic       DROP
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_ECHO  = 3'd2,
        S_WINA  = 3'd3,
        S_LOSEA = 3'd4
    } state_t;

    localparam logic [7:0] c_PLAY_TICKS = 8'(PLAY_TICKS);
    localparam logic [7:0] c_ECHO_TICKS = 8'(ECHO_TICKS);
    // Step index is 8 bits so the full WIN_LOOPS range (4*63-1) fits.
    localparam logic [7:0] c_WIN_LAST   = 8'(4 * WIN_LOOPS - 1);
    localparam logic [7:0] c_LOSE_LAST  = 8'(2 * LOSE_BLINKS - 1);

    state_t     r_state, w_state;
    logic [7:0] r_rem, w_rem;
    logic [7:0] r_step, w_step;
    logic [1:0] r_color, w_color;

    logic [3:0] w_led;
    logic [1:0] w_tone;
    logic       w_tone_en;
    logic       w_busy;
    logic       w_drop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_rem   <= 8'd0;
            r_step  <= 8'd0;
            r_color <= 2'd0;
            LED     <= 4'd0;
            TONE    <= 2'd0;
            TONE_EN <= 1'b0;
            BUSY    <= 1'b0;
            DROP    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_step  <= w_step;
            r_color <= w_color;
            LED     <= w_led;
            TONE    <= w_tone;
            TONE_EN <= w_tone_en;
            BUSY    <= w_busy;
            DROP    <= w_drop;
        end
    end

    // Next-state: arbitration, tick counting and the single DROP pulse.
    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_step  = r_step;
        w_color = r_color;
        w_drop  = 1'b0;

        case (r_state)
            S_WINA, S_LOSEA: begin
                w_drop = PB_REQ | IN_VALID | WIN | LOSE;
                if (TICK) begin
                    if (r_step == ((r_state == S_WINA) ? c_WIN_LAST : c_LOSE_LAST)) begin
                        w_state = S_IDLE;
                        w_step  = 8'd0;
                        w_rem   = 8'd0;
                    end else begin
                        w_step = r_step + 8'd1;
                    end
                end
            end
            default: begin
                if (LOSE) begin
                    w_state = S_LOSEA;
                    w_step  = 8'd0;
                    w_rem   = 8'd1;
                    w_drop  = WIN | IN_VALID | PB_REQ;
                end else if (WIN) begin
                    w_state = S_WINA;
                    w_step  = 8'd0;
                    w_rem   = 8'd1;
                    w_drop  = IN_VALID | PB_REQ;
                end else if (IN_VALID) begin
                    w_state = S_ECHO;
                    w_color = IN;
                    w_rem   = c_ECHO_TICKS;
                    w_drop  = PB_REQ;
                end else if (PB_REQ && r_state != S_ECHO) begin
                    w_state = S_PLAY;
                    w_color = PB_COLOR;
                    w_rem   = c_PLAY_TICKS;
                end else begin
                    // A playback request during echo is refused but time keeps running.
                    w_drop = PB_REQ;
                    if (TICK && r_state != S_IDLE) begin
                        if (r_rem == 8'd1) begin
                            w_state = S_IDLE;
                            w_rem   = 8'd0;
                        end else begin
                            w_rem = r_rem - 8'd1;
                        end
                    end
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        w_led     = 4'd0;
        w_tone    = 2'd0;
        w_tone_en = 1'b0;
        w_busy    = 1'b0;
        case (w_state)
            S_PLAY, S_ECHO: begin
                w_led     = 4'b0001 << w_color;
                w_tone    = w_color;
                w_tone_en = 1'b1;
            end
            S_WINA: begin
                w_led     = 4'b0001 << w_step[1:0];
                w_tone    = w_step[1:0];
                w_tone_en = 1'b1;
                w_busy    = 1'b1;
            end
            S_LOSEA: begin
                w_busy = 1'b1;
                if (!w_step[0]) begin
                    w_led     = 4'b1111;
                    w_tone_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_led_tone_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_tone_arbiter
// Brief    : Directed self-checking bench for led_tone_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_tone_arbiter;

    logic       CLK;
    logic       RST_N;
    logic       TICK;
    logic       PB_REQ;
    logic [1:0] PB_COLOR;
    logic       IN_VALID;
    logic [1:0] IN;
    logic       WIN;
    logic       LOSE;
    logic [3:0] LED;
    logic [1:0] TONE;
    logic       TONE_EN;
    logic       BUSY;
    logic       DROP;

    int vecs = 0;
    int errs = 0;

    led_tone_arbiter #(
        .PLAY_TICKS (3),
        .ECHO_TICKS (2),
        .WIN_LOOPS  (2),
        .LOSE_BLINKS(3)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .TICK    (TICK),
        .PB_REQ  (PB_REQ),
        .PB_COLOR(PB_COLOR),
        .IN_VALID(IN_VALID),
        .IN      (IN),
        .WIN     (WIN),
        .LOSE    (LOSE),
        .LED     (LED),
        .TONE    (TONE),
        .TONE_EN (TONE_EN),
        .BUSY    (BUSY),
        .DROP    (DROP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick1();
        TICK = 1'b1;
        clk1();
        TICK = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; TICK = 1'b0; PB_REQ = 1'b0; PB_COLOR = 2'd0;
        IN_VALID = 1'b0; IN = 2'd0; WIN = 1'b0; LOSE = 1'b0;
        clk1(); clk1();
        vecs++;
        if ({LED, TONE, TONE_EN, BUSY, DROP} !== 9'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %b required 000000000", {LED, TONE, TONE_EN, BUSY, DROP});
        end
        RST_N = 1'b1;
        clk1();
        vecs++;
        if ({LED, TONE_EN, BUSY, DROP} !== 7'd0) begin
            errs++;
            $display("FAIL idle_after_reset: got %b required 0000000", {LED, TONE_EN, BUSY, DROP});
        end
    endtask

    task automatic test_playback();
        PB_REQ = 1'b1; PB_COLOR = 2'd2;
        clk1();
        PB_REQ = 1'b0;
        vecs++;
        if (LED !== 4'b0100 || TONE !== 2'd2 || TONE_EN !== 1'b1 || DROP !== 1'b0) begin
            errs++;
            $display("FAIL play_grant: got led=%b tone=%0d en=%b drop=%b required led=0100 tone=2 en=1 drop=0",
                     LED, TONE, TONE_EN, DROP);
        end
        for (int k = 1; k <= 3; k++) begin
            clk1(); clk1(); clk1();
            tick1();
            vecs++;
            if (LED !== ((k < 3) ? 4'b0100 : 4'b0000) || DROP !== 1'b0) begin
                errs++;
                $display("FAIL play_tick%0d: got led=%b drop=%b required led=%b drop=0",
                         k, LED, DROP, (k < 3) ? 4'b0100 : 4'b0000);
            end
        end
    endtask

    task automatic test_echo_preempt();
        PB_REQ = 1'b1; PB_COLOR = 2'd1;
        clk1();
        PB_REQ = 1'b0;
        vecs++;
        if (LED !== 4'b0010) begin
            errs++;
            $display("FAIL echo_pre_play: got %b required 0010", LED);
        end
        clk1();
        IN_VALID = 1'b1; IN = 2'd3;
        clk1();
        IN_VALID = 1'b0;
        vecs++;
        if (LED !== 4'b1000 || TONE !== 2'd3 || DROP !== 1'b0) begin
            errs++;
            $display("FAIL echo_preempt: got led=%b tone=%0d drop=%b required led=1000 tone=3 drop=0", LED, TONE, DROP);
        end
        tick1();
        vecs++;
        if (LED !== 4'b1000) begin
            errs++;
            $display("FAIL echo_tick1: got %b required 1000", LED);
        end
        tick1();
        vecs++;
        if (LED !== 4'b0000 || TONE_EN !== 1'b0) begin
            errs++;
            $display("FAIL echo_tick2: got led=%b en=%b required led=0000 en=0", LED, TONE_EN);
        end
    endtask

    task automatic test_contention();
        PB_REQ = 1'b1; PB_COLOR = 2'd0; IN_VALID = 1'b1; IN = 2'd1;
        clk1();
        PB_REQ = 1'b0; IN_VALID = 1'b0;
        vecs++;
        if (LED !== 4'b0010 || DROP !== 1'b1) begin
            errs++;
            $display("FAIL contention: got led=%b drop=%b required led=0010 drop=1", LED, DROP);
        end
        clk1();
        vecs++;
        if (DROP !== 1'b0) begin
            errs++;
            $display("FAIL contention_drop_once: got %b required 0", DROP);
        end
        tick1(); tick1();
        vecs++;
        if (LED !== 4'b0000) begin
            errs++;
            $display("FAIL contention_clear: got %b required 0000", LED);
        end
    endtask

    task automatic test_back_to_back();
        PB_REQ = 1'b1; PB_COLOR = 2'd3;
        clk1();
        PB_REQ = 1'b0;
        tick1(); tick1();
        TICK = 1'b1; PB_REQ = 1'b1; PB_COLOR = 2'd1;
        clk1();
        TICK = 1'b0; PB_REQ = 1'b0;
        vecs++;
        if (LED !== 4'b0010 || TONE !== 2'd1) begin
            errs++;
            $display("FAIL expire_and_request: got led=%b tone=%0d required led=0010 tone=1", LED, TONE);
        end
        tick1(); tick1();
        vecs++;
        if (LED !== 4'b0010) begin
            errs++;
            $display("FAIL retrigger_hold: got %b required 0010", LED);
        end
        tick1();
        vecs++;
        if (LED !== 4'b0000) begin
            errs++;
            $display("FAIL retrigger_clear: got %b required 0000", LED);
        end
    endtask

    task automatic test_win();
        logic [3:0] exp_led;
        WIN = 1'b1;
        clk1();
        WIN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_led = 4'b0001 << (i % 4);
            vecs++;
            if (LED !== exp_led || TONE !== 2'(i % 4) || TONE_EN !== 1'b1 || BUSY !== 1'b1) begin
                errs++;
                $display("FAIL win_step%0d: got led=%b tone=%0d en=%b busy=%b required led=%b tone=%0d en=1 busy=1",
                         i, LED, TONE, TONE_EN, BUSY, exp_led, i % 4);
            end
            if (i == 2) begin
                PB_REQ = 1'b1; PB_COLOR = 2'd0;
                clk1();
                PB_REQ = 1'b0;
                vecs++;
                if (DROP !== 1'b1 || LED !== exp_led) begin
                    errs++;
                    $display("FAIL win_drop: got drop=%b led=%b required drop=1 led=%b", DROP, LED, exp_led);
                end
                clk1();
                vecs++;
                if (DROP !== 1'b0) begin
                    errs++;
                    $display("FAIL win_drop_once: got %b required 0", DROP);
                end
            end
            tick1();
        end
        vecs++;
        if (LED !== 4'b0000 || BUSY !== 1'b0 || TONE_EN !== 1'b0) begin
            errs++;
            $display("FAIL win_end: got led=%b busy=%b en=%b required led=0000 busy=0 en=0", LED, BUSY, TONE_EN);
        end
    endtask

    task automatic test_lose();
        logic [3:0] exp_led;
        WIN = 1'b1; LOSE = 1'b1;
        clk1();
        WIN = 1'b0; LOSE = 1'b0;
        vecs++;
        if (LED !== 4'b1111 || TONE_EN !== 1'b1 || BUSY !== 1'b1 || DROP !== 1'b1) begin
            errs++;
            $display("FAIL lose_grant: got led=%b en=%b busy=%b drop=%b required led=1111 en=1 busy=1 drop=1",
                     LED, TONE_EN, BUSY, DROP);
        end
        for (int i = 1; i <= 6; i++) begin
            tick1();
            exp_led = (i < 6 && (i % 2) == 0) ? 4'b1111 : 4'b0000;
            vecs++;
            if (LED !== exp_led || TONE_EN !== exp_led[0] || BUSY !== (i < 6) || DROP !== 1'b0) begin
                errs++;
                $display("FAIL lose_tick%0d: got led=%b en=%b busy=%b drop=%b required led=%b en=%b busy=%b drop=0",
                         i, LED, TONE_EN, BUSY, DROP, exp_led, exp_led[0], i < 6);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        IN_VALID = 1'b1; IN = 2'd2;
        clk1();
        IN_VALID = 1'b0;
        vecs++;
        if (LED !== 4'b0100) begin
            errs++;
            $display("FAIL reset_pre_echo: got %b required 0100", LED);
        end
        #2;
        RST_N = 1'b0;
        #1;
        vecs++;
        if (LED !== 4'b0000 || TONE_EN !== 1'b0 || BUSY !== 1'b0) begin
            errs++;
            $display("FAIL async_reset_echo: got led=%b en=%b busy=%b required all 0", LED, TONE_EN, BUSY);
        end
        RST_N = 1'b1;
        clk1();
        WIN = 1'b1;
        clk1();
        WIN = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        vecs++;
        if (LED !== 4'b0000 || BUSY !== 1'b0) begin
            errs++;
            $display("FAIL async_reset_win: got led=%b busy=%b required led=0000 busy=0", LED, BUSY);
        end
        RST_N = 1'b1;
        clk1();
        PB_REQ = 1'b1; PB_COLOR = 2'd0;
        clk1();
        PB_REQ = 1'b0;
        vecs++;
        if (LED !== 4'b0001 || BUSY !== 1'b0) begin
            errs++;
            $display("FAIL after_reset_play: got led=%b busy=%b required led=0001 busy=0", LED, BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_playback();
        test_echo_preempt();
        test_contention();
        test_back_to_back();
        test_win();
        test_lose();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
